// File: rtl/axi_master_pkg.sv
// Shared state encoding and fixed AXI burst attributes for axi_cpu_master.
`include "AXI_define.svh"

package axi_master_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        AW   = 3'd3,
        W    = 3'd4,
        B    = 3'd5
    } state_t;

    localparam logic [`AXI_SIZE_BITS-1:0]  SIZE_WORD  = 3'b010;
    localparam logic [`AXI_BURST_BITS-1:0] BURST_INCR = 2'b01;
    localparam logic [`AXI_LEN_BITS-1:0]   LEN_SINGLE = 4'd0;

endpackage

// File: rtl/AXI_define.svh
// AXI4 single-master signal widths shared by the CPU bridge slice.
`ifndef AXI_DEFINE_SVH
`define AXI_DEFINE_SVH

`define AXI_ID_BITS    4
`define AXI_ADDR_BITS  32
`define AXI_DATA_BITS  32
`define AXI_STRB_BITS  4
`define AXI_LEN_BITS   4
`define AXI_SIZE_BITS  3
`define AXI_BURST_BITS 2
`define AXI_RESP_BITS  2

`endif

// File: rtl/axi_cpu_master.sv
// CPU-to-AXI4 single-beat bridge: one outstanding read or write at a time.
// Optional MASTER_RESP_ERR_EN reports nonzero RRESP/BRESP on err.
`include "AXI_define.svh"

module axi_cpu_master
    import axi_master_pkg::*;
#(
    parameter logic [`AXI_ID_BITS-1:0] MASTER_ID = 4'd0
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic                       req_valid,
    input  logic                       req_write,
    input  logic [`AXI_ADDR_BITS-1:0]  req_addr,
    input  logic [`AXI_DATA_BITS-1:0]  req_wdata,
    input  logic [`AXI_STRB_BITS-1:0]  req_wstrb,
    output logic                       stall,
    output logic                       done,
    output logic [`AXI_DATA_BITS-1:0]  rdata,
    output logic                       err,
    output logic [`AXI_ID_BITS-1:0]    ARID,
    output logic [`AXI_ADDR_BITS-1:0]  ARADDR,
    output logic [`AXI_LEN_BITS-1:0]   ARLEN,
    output logic [`AXI_SIZE_BITS-1:0]  ARSIZE,
    output logic [`AXI_BURST_BITS-1:0] ARBURST,
    output logic                       ARVALID,
    input  logic                       ARREADY,
    input  logic [`AXI_ID_BITS-1:0]    RID,
    input  logic [`AXI_DATA_BITS-1:0]  RDATA,
    input  logic [`AXI_RESP_BITS-1:0]  RRESP,
    input  logic                       RLAST,
    input  logic                       RVALID,
    output logic                       RREADY,
    output logic [`AXI_ID_BITS-1:0]    AWID,
    output logic [`AXI_ADDR_BITS-1:0]  AWADDR,
    output logic [`AXI_LEN_BITS-1:0]   AWLEN,
    output logic [`AXI_SIZE_BITS-1:0]  AWSIZE,
    output logic [`AXI_BURST_BITS-1:0] AWBURST,
    output logic                       AWVALID,
    input  logic                       AWREADY,
    output logic [`AXI_DATA_BITS-1:0]  WDATA,
    output logic [`AXI_STRB_BITS-1:0]  WSTRB,
    output logic                       WLAST,
    output logic                       WVALID,
    input  logic                       WREADY,
    input  logic [`AXI_ID_BITS-1:0]    BID,
    input  logic [`AXI_RESP_BITS-1:0]  BRESP,
    input  logic                       BVALID,
    output logic                       BREADY
);

    state_t state, state_nxt;

    logic [`AXI_ADDR_BITS-1:0] addr_q;
    logic [`AXI_DATA_BITS-1:0] wdata_q;
    logic [`AXI_STRB_BITS-1:0] wstrb_q;

    logic accept;
    logic r_hs;
    logic b_hs;

    // Single-beat transfers only, so IDs/RLAST carry no sequencing information.
    logic unused_inputs;
    assign unused_inputs = ^{RID, BID, RLAST, RRESP, BRESP};

    assign accept = (state == IDLE) && req_valid;
    assign r_hs   = (state == R) && RVALID;
    assign b_hs   = (state == B) && BVALID;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (req_valid) state_nxt = req_write ? AW : AR;
            AR:   if (ARREADY)   state_nxt = R;
            R:    if (RVALID)    state_nxt = IDLE;
            AW:   if (AWREADY)   state_nxt = W;
            W:    if (WREADY)    state_nxt = B;
            B:    if (BVALID)    state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    // Payload comes only from the capture register, which loads solely in IDLE,
    // so every VALID holds with stable payload until its handshake.
    assign ARVALID = (state == AR);
    assign RREADY  = (state == R);
    assign AWVALID = (state == AW);
    assign WVALID  = (state == W);
    assign BREADY  = (state == B);

    assign ARID    = MASTER_ID;
    assign ARADDR  = addr_q;
    assign ARLEN   = LEN_SINGLE;
    assign ARSIZE  = SIZE_WORD;
    assign ARBURST = BURST_INCR;

    assign AWID    = MASTER_ID;
    assign AWADDR  = addr_q;
    assign AWLEN   = LEN_SINGLE;
    assign AWSIZE  = SIZE_WORD;
    assign AWBURST = BURST_INCR;

    assign WDATA   = wdata_q;
    assign WSTRB   = wstrb_q;
    assign WLAST   = 1'b1;

    assign stall = (state != IDLE) || (req_valid && !done);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= 4'h0;
        end else if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rdata <= '0;
            done  <= 1'b0;
        end else begin
            done <= r_hs || b_hs;
            if (r_hs) rdata <= RDATA;
        end
    end

`ifdef MASTER_RESP_ERR_EN
    // err rises together with done and is held until the next request is taken.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)   err <= 1'b0;
        else if (r_hs)  err <= |RRESP;
        else if (b_hs)  err <= |BRESP;
        else if (accept) err <= 1'b0;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_cpu_master.sv
// Directed bench for axi_cpu_master: read, write, back-pressure, back-to-back, reset, error.
`timescale 1ns/1ps

module tb_axi_cpu_master;

`ifdef MASTER_RESP_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        req_valid, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        stall, done, err;
    logic [31:0] rdata;
    logic [3:0]  ARID, AWID, RID, BID;
    logic [31:0] ARADDR, AWADDR, RDATA, WDATA;
    logic [3:0]  ARLEN, AWLEN, WSTRB;
    logic [2:0]  ARSIZE, AWSIZE;
    logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY;
    logic        BVALID, BREADY;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 ACLK = ~ACLK;

    axi_cpu_master #(.MASTER_ID(4'd0)) u_dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .stall(stall), .done(done), .rdata(rdata), .err(err),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
        .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        chk("rst_vr", {27'd0, ARVALID, AWVALID, WVALID, RREADY, BREADY}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_wstrb", {28'd0, WSTRB}, 32'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        tick();
    endtask

    task automatic test_read();
        RDATA     = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_0010;
        #1;
        chk("rd_stall0", {31'd0, stall}, 32'd1);
        tick();
        req_valid = 1'b0;
        chk("rd_c1_valid", {27'd0, ARVALID, AWVALID, WVALID, RREADY, BREADY}, 32'b10000);
        chk("rd_araddr", ARADDR, 32'h10);
        chk("rd_attr", {21'd0, ARID, ARLEN, ARSIZE}, {21'd0, 4'd0, 4'd0, 3'b010});
        chk("rd_burst", {30'd0, ARBURST}, 32'd1);
        chk("rd_c1_done", {31'd0, done}, 32'd0);
        tick();
        chk("rd_c2_valid", {27'd0, ARVALID, AWVALID, WVALID, RREADY, BREADY}, 32'b00010);
        chk("rd_c2_done", {31'd0, done}, 32'd0);
        tick();
        chk("rd_c3_done", {31'd0, done}, 32'd1);
        chk("rd_rdata", rdata, 32'hDEAD_BEEF);
        chk("rd_c3_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("rd_c4_done", {31'd0, done}, 32'd0);
    endtask

    task automatic test_write();
        RDATA     = 32'h5555_AAAA;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_0020;
        req_wdata = 32'h1234_5678;
        req_wstrb = 4'b0011;
        tick();
        req_valid = 1'b0;
        chk("wr_c1_valid", {27'd0, ARVALID, AWVALID, WVALID, RREADY, BREADY}, 32'b01000);
        chk("wr_awaddr", AWADDR, 32'h20);
        chk("wr_awattr", {21'd0, AWID, AWLEN, AWSIZE}, {21'd0, 4'd0, 4'd0, 3'b010});
        chk("wr_awburst", {30'd0, AWBURST}, 32'd1);
        tick();
        chk("wr_c2_valid", {27'd0, ARVALID, AWVALID, WVALID, RREADY, BREADY}, 32'b00100);
        chk("wr_wdata", WDATA, 32'h1234_5678);
        chk("wr_wstrb_last", {27'd0, WSTRB, WLAST}, {27'd0, 4'b0011, 1'b1});
        tick();
        chk("wr_c3_valid", {27'd0, ARVALID, AWVALID, WVALID, RREADY, BREADY}, 32'b00001);
        chk("wr_c3_done", {31'd0, done}, 32'd0);
        tick();
        chk("wr_c4_done", {31'd0, done}, 32'd1);
        chk("wr_rdata_hold", rdata, 32'hDEAD_BEEF);
        chk("wr_c4_err", {31'd0, err}, 32'd0);
        tick();
        chk("wr_c5_done", {31'd0, done}, 32'd0);
    endtask

    task automatic test_ar_backpressure();
        ARREADY   = 1'b0;
        RDATA     = 32'hCAFE_0044;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_0044;
        tick();
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            chk("bp_arvalid", {31'd0, ARVALID}, 32'd1);
            chk("bp_araddr", ARADDR, 32'h44);
            chk("bp_stall", {31'd0, stall}, 32'd1);
            if (i < 4) tick();
        end
        ARREADY = 1'b1;
        tick();
        chk("bp_rready", {30'd0, ARVALID, RREADY}, 32'b01);
        tick();
        chk("bp_done", {31'd0, done}, 32'd1);
        chk("bp_rdata", rdata, 32'hCAFE_0044);
        tick();
    endtask

    task automatic test_back_to_back();
        RDATA     = 32'h0BAD_F00D;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_0030;
        tick();
        chk("b2b_ar", {31'd0, ARVALID}, 32'd1);
        tick();
        tick();
        chk("b2b_rd_done", {31'd0, done}, 32'd1);
        chk("b2b_rd_stall", {31'd0, stall}, 32'd0);
        req_write = 1'b1;
        req_addr  = 32'h0000_0040;
        req_wdata = 32'hA5A5_5A5A;
        req_wstrb = 4'b1111;
        tick();
        req_valid = 1'b0;
        chk("b2b_awvalid", {27'd0, ARVALID, AWVALID, WVALID, RREADY, BREADY}, 32'b01000);
        chk("b2b_awaddr", AWADDR, 32'h40);
        chk("b2b_rdata", rdata, 32'h0BAD_F00D);
        tick();
        chk("b2b_wdata", WDATA, 32'hA5A5_5A5A);
        tick();
        tick();
        chk("b2b_wr_done", {31'd0, done}, 32'd1);
        tick();
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_0050;
        req_wdata = 32'h7777_8888;
        req_wstrb = 4'b1000;
        tick();
        req_valid = 1'b0;
        tick();
        chk("rm_in_w", {31'd0, WVALID}, 32'd1);
        ARESETn = 1'b0;
        #1;
        chk("rm_wvalid", {31'd0, WVALID}, 32'd0);
        chk("rm_state", {29'd0, u_dut.state}, {29'd0, axi_master_pkg::IDLE});
        chk("rm_rdata", rdata, 32'd0);
        chk("rm_wstrb", {28'd0, WSTRB}, 32'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rm_no_done", {28'd0, done, ARVALID, AWVALID, WVALID}, 32'd0);
        end
    endtask

    task automatic test_resp_err();
        BRESP     = 2'b11;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_0060;
        req_wdata = 32'h0000_0001;
        req_wstrb = 4'b0001;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("er_done", {31'd0, done}, 32'd1);
        chk("er_err", {31'd0, err}, {31'd0, ERR_EXP});
        tick();
        chk("er_hold", {31'd0, err}, {31'd0, ERR_EXP});
        BRESP     = 2'b00;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_0064;
        tick();
        req_valid = 1'b0;
        chk("er_clear", {31'd0, err}, 32'd0);
        tick();
        tick();
        chk("er_rd_done", {30'd0, done, err}, 32'b10);
        tick();
    endtask

    initial begin
        ARESETn   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        ARREADY   = 1'b1;
        AWREADY   = 1'b1;
        WREADY    = 1'b1;
        RVALID    = 1'b1;
        BVALID    = 1'b1;
        RID       = 4'd3;
        BID       = 4'd5;
        RDATA     = '0;
        RRESP     = 2'b00;
        RLAST     = 1'b1;
        BRESP     = 2'b00;

        test_reset();
        test_read();
        test_write();
        test_ar_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_resp_err();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_cpu_master.md
AXI_CPU_MASTER -- requirements
Module: axi_cpu_master

Interface
REQ-001 SHALL have parameter MASTER_ID, default 4'd0, which is the AXI ID driven on ARID/AWID.
REQ-002 SHALL have port ACLK, input, 1 bit: clock; all state updates on its rising edge.
REQ-003 SHALL have port ARESETn, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have CPU-side inputs: req_valid 1 (request present), req_write 1 (1=write, 0=read), req_addr 32, req_wdata 32, req_wstrb 4 (active-high byte enables).
REQ-005 SHALL have CPU-side outputs: stall 1 (hold CPU), done 1 (one-cycle completion pulse), rdata 32 (read result), err 1 (response error).
REQ-006 SHALL have AR channel outputs ARID 4, ARADDR 32, ARLEN 4, ARSIZE 3, ARBURST 2, ARVALID 1, and input ARREADY 1.
REQ-007 SHALL have R channel inputs RID 4, RDATA 32, RRESP 2, RLAST 1, RVALID 1, and output RREADY 1.
REQ-008 SHALL have AW channel outputs AWID 4, AWADDR 32, AWLEN 4, AWSIZE 3, AWBURST 2, AWVALID 1, and input AWREADY 1.
REQ-009 SHALL have W channel outputs WDATA 32, WSTRB 4, WLAST 1, WVALID 1, and input WREADY 1.
REQ-010 SHALL have B channel inputs BID 4, BRESP 2, BVALID 1, and output BREADY 1.

Function
REQ-011 SHALL implement FSM states IDLE, AR, R, AW, W, B.
REQ-012 IDLE with req_valid=1 SHALL latch addr/wdata/wstrb and go to AW if req_write=1, else to AR.
REQ-013 AR SHALL assert ARVALID with latched address and go to R on ARVALID&&ARREADY.
REQ-014 R SHALL assert RREADY and, on RVALID&&RREADY, latch RDATA into rdata and return to IDLE.
REQ-015 AW SHALL assert AWVALID and go to W on AWVALID&&AWREADY.
REQ-016 W SHALL assert WVALID with WLAST=1 and latched WDATA/WSTRB, and go to B on WVALID&&WREADY.
REQ-017 B SHALL assert BREADY and return to IDLE on BVALID&&BREADY.
REQ-018 Once asserted, a VALID signal SHALL hold until its handshake, with all payload stable.
REQ-019 ARLEN/AWLEN SHALL be 4'd0, ARSIZE/AWSIZE 3'b010, ARBURST/AWBURST 2'b01, and ARID/AWID MASTER_ID.
REQ-020 done SHALL pulse for exactly one cycle, registered, in the cycle after the R or B handshake.
REQ-021 stall SHALL be (state!=IDLE) || (req_valid && !done) (combinational).
REQ-022 A request arriving in the done cycle SHALL be accepted in that same cycle.
REQ-023 Minimum latency with ready/valid always high SHALL be: read 3 cycles and write 4 cycles from request to done.
REQ-024 rdata SHALL hold its last read value until the next read handshake.
REQ-025 RID/BID and RLAST SHALL be ignored for sequencing.
REQ-026 The channels SHALL never be mixed: at most one VALID is asserted at any time.

Reset
REQ-027 ARESETn low SHALL immediately force the FSM to IDLE and drive all VALID/READY, done and err to 0.
REQ-028 ARESETn low SHALL clear rdata and the latched addr/wdata to 0 and the latched wstrb to 4'h0.
REQ-029 Reset mid-transaction SHALL abandon the transaction, with no done pulse after release.

Configuration
REQ-030 Macro MASTER_RESP_ERR_EN, when defined, SHALL set err to 1 in the done cycle if the captured RRESP/BRESP is nonzero, and hold err until the next accepted request.
REQ-031 Without MASTER_RESP_ERR_EN, err SHALL be tied to 0 and responses SHALL be ignored.

Structure
REQ-032 Package axi_master_pkg SHALL hold the state enum, SIZE_WORD=3'b010, BURST_INCR=2'b01 and LEN_SINGLE=4'd0; widths SHALL come from AXI_define.svh.
REQ-033 No sub-module SHALL be used; the request capture register SHALL be inline.

Verification
REQ-034 Read 0x0000_0010 with all readies high and RDATA=0xDEAD_BEEF SHALL give done at cycle 3, rdata=0xDEADBEEF and ARADDR=0x10 while ARVALID is high.
REQ-035 Write 0x0000_0020, data 0x1234_5678, strb 4'b0011 SHALL give WSTRB=0011, WLAST=1 and done at cycle 4.
REQ-036 ARREADY held low for 5 cycles SHALL keep ARVALID=1 and ARADDR stable throughout, and keep stall=1.
REQ-037 Back-to-back read then write with req_valid held SHALL accept the write in the read's done cycle, with no idle gap.
REQ-038 With MASTER_RESP_ERR_EN defined, BRESP=2'b11 SHALL give err=1 at done, cleared by the next request.
REQ-039 ARESETn pulsed low while in W state SHALL give WVALID=0 immediately, state IDLE, and no done pulse.
